// File: rtl/red_seq.sv
// red_seq: multi-cycle signed sub-word reduction for the RED path.
// Ports: clk, rst (sync, active-high), start, A, B in; busy, done, result out.
module red_seq #(
    parameter int WIDTH   = 16,
    parameter int NIB_W   = 4,
    parameter int NUM_NIB = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int NIBS  = 2 * NUM_NIB;
    localparam int SH_W  = 2 * WIDTH;
    localparam int CNT_W = $clog2(NIBS);
    // Worst case sum magnitude needs NIB_W + log2(NIBS) bits plus sign.
    localparam int ACC_W = NIB_W + CNT_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [SH_W-1:0]    sh_q, sh_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic [NIB_W-1:0]   nib;
    logic [ACC_W-1:0]   nib_ext;
    logic [ACC_W-1:0]   sum;

    assign nib     = sh_q[NIB_W-1:0];
    assign nib_ext = {{(ACC_W-NIB_W){nib[NIB_W-1]}}, nib};
    assign sum     = acc_q + nib_ext;

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // A occupies the low half so its nibbles fold first.
                    sh_d    = {B, A};
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_ACCUM;
                end else begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_ACCUM: begin
                acc_d = sum;
                sh_d  = sh_q >> NIB_W;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = {{(WIDTH-ACC_W){sum[ACC_W-1]}}, sum};
                    state_d  = S_DONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sh_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_red_seq.sv
// tb_red_seq: scoreboard bench for red_seq.
// Drives and samples on the falling clock edge.
module tb_red_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        busy;
    logic        done;
    logic [15:0] result;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_exp = '0;

    red_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] a,
                                          input logic [15:0] b);
        int s;
        logic [31:0] w;
        logic signed [3:0] n;
        s = 0;
        w = {b, a};
        for (int i = 0; i < 8; i++) begin
            n = w[i*4 +: 4];
            s += int'(n);
        end
        return 16'(s);
    endfunction

    // Called at a falling edge; leaves at the next falling edge,
    // i.e. just after the accepting rising edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        A     = a;
        B     = b;
        start = 1'b1;
        exp_q.push_back(model(a, b));
        @(negedge clk);
        start = 1'b0;
        A     = '0;
        B     = '0;
    endtask

    // Samples falling edges until done; returns edges since accept.
    task automatic wait_done(output int lat, output int nbusy);
        logic [15:0] e;
        bit seen;
        lat   = 0;
        nbusy = 0;
        seen  = 0;
        for (int k = 1; k <= 20; k++) begin
            if (done) begin
                lat  = k - 1;
                seen = 1;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
        end
        if (!seen) begin
            chk("timeout", 32'd0, 32'd1);
        end else if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            last_exp = e;
            chk("result", {16'h0, result}, {16'h0, e});
        end
    endtask

    task automatic plain_op(input string tag, input logic [15:0] a,
                            input logic [15:0] b);
        int lat, nb;
        issue(a, b);
        wait_done(lat, nb);
        chk({tag, "_lat"}, lat, 8);
        chk({tag, "_busy"}, nb, 8);
        @(negedge clk);
        chk({tag, "_done_drop"}, {31'h0, done}, 0);
        chk({tag, "_hold"}, {16'h0, result}, {16'h0, last_exp});
    endtask

    initial begin
        int lat, nb;
        bit saw;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_done", {31'h0, done}, 0);
        chk("rst_result", {16'h0, result}, 0);

        plain_op("t1", 16'h1111, 16'h1111);
        chk("t1_val", {16'h0, last_exp}, 32'h0008);
        plain_op("t2", 16'h8888, 16'h8888);
        plain_op("t3", 16'h7777, 16'h7777);
        plain_op("t4", 16'hF0F0, 16'h0102);
        plain_op("rnd", 16'($urandom), 16'($urandom));

        // start during ACCUM must be ignored
        issue(16'h1111, 16'h1111);
        repeat (2) @(negedge clk);
        A     = 16'h7777;
        B     = 16'h7777;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A     = '0;
        B     = '0;
        wait_done(lat, nb);
        @(negedge clk);

        // reset mid-operation aborts with no done pulse
        issue(16'h1111, 16'h1111);
        void'(exp_q.pop_back());
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'h0, busy}, 0);
        chk("abort_done", {31'h0, done}, 0);
        chk("abort_result", {16'h0, result}, 0);
        saw = 0;
        repeat (12) begin
            if (done) saw = 1;
            @(negedge clk);
        end
        chk("abort_no_done", {31'h0, saw}, 0);
        plain_op("t5b", 16'h0001, 16'h0000);

        // back-to-back: second start lands in the DONE cycle
        issue(16'h1111, 16'h1111);
        wait_done(lat, nb);
        chk("b2b_lat1", lat, 8);
        issue(16'hFFFF, 16'hFFFF);
        chk("b2b_rebusy", {31'h0, busy}, 1);
        chk("b2b_old_res", {16'h0, result}, 32'h0008);
        wait_done(lat, nb);
        chk("b2b_lat2", lat, 8);
        chk("b2b_val", {16'h0, last_exp}, 32'hFFF8);

        chk("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
